sm_arbiter: RTL and testbench
=============================

Name: sm_arbiter

Overview:
- Shares one sum-every-3 datapath between NREQ independent sample streams.
- The datapath has input `i_dval`/`i` and output `o_dval`/`o`, and produces one sum per 3 valid input samples.
- The arbiter grants the datapath to one requester for a whole group of 3 samples, using round-robin priority.
- It records the owner of each issued group in a tag FIFO and routes each returned sum back to its owner. Datapath latency is therefore opaque to the arbiter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, input sample width.
- OW, 10, datapath sum width (≥ DW+2).
- TAGQ, 4, tag FIFO depth, i.e. the maximum number of groups outstanding in the datapath (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester sample valid.
- req_ready  out  NREQ  per-requester sample accept; combinational.
- req_data  in  NREQ*DW  packed samples; requester k occupies bits [k*DW +: DW].
- dp_i_dval  out  1  to datapath `i_dval`; registered.
- dp_i  out  DW  to datapath `i`; registered.
- dp_o_dval  in  1  from datapath `o_dval`.
- dp_o  in  OW  from datapath `o`.
- rsp_dval  out  NREQ  one-hot result valid; registered.
- rsp_data  out  OW  result value; registered.
- busy  out  1  high when in LOCK or when the tag FIFO is non-empty.
- err_orphan  out  1  sticky flag: a result arrived while the tag FIFO was empty.

Behaviour:
- Reset (rst=0, async), all of the following are 0:
  - state=IDLE, grant, rr_ptr=NREQ-1 (so requester 0 has first priority), cnt.
  - Tag FIFO empty.
  - dp_i_dval, dp_i, rsp_dval, rsp_data, err_orphan, req_ready.
- A reset mid-group discards the partial group and all tags. The datapath shares the same rst, so its partial sum is also cleared.
- FSM states: IDLE, LOCK.
- IDLE:
  - req_ready=0.
  - If the OR of req_valid is 1 and the tag FIFO is not full:
    - grant = first requester with valid=1, searching from rr_ptr+1 upward with wrap-around.
    - Push grant into the tag FIFO.
    - cnt=0; go to LOCK.
  - Otherwise stay in IDLE.
- LOCK:
  - req_ready[grant]=1; all other req_ready bits are 0.
  - Accept occurs when req_valid[grant]=1.
  - On accept: next cycle dp_i_dval=1 and dp_i=req_data[grant]; cnt increments.
  - On a cycle without accept: next cycle dp_i_dval=0. The group stays locked; gaps are legal because the datapath counts only valid samples.
  - On the 3rd accept (cnt==2): rr_ptr=grant; go to IDLE.
- Throughput: at most 3 samples per 4 cycles. The IDLE grant cycle is a bubble.
- Input latency: req accept → dp_i_dval is exactly 1 cycle.
- Tag FIFO:
  - Full/empty are evaluated on the current occupancy.
  - A push in the same cycle as a pop while full is not allowed. The grant waits one cycle; this is conservative.
  - Pointers wrap modulo TAGQ.
- Return path:
  - When dp_o_dval=1 and the FIFO is non-empty: pop tag t. Next cycle rsp_dval=(1<<t) and rsp_data=dp_o.
  - When dp_o_dval=1 and the FIFO is empty: no pop, rsp_dval stays 0, err_orphan is set (cleared only by reset).
  - Otherwise rsp_dval=0 and rsp_data holds its value.
- Push and pop in the same cycle (FIFO not full) are both performed; occupancy is unchanged.
- Results are returned in issue order. No reordering is required because the datapath is in-order.
- No width conversion: dp_i is req_data passed unchanged; rsp_data is dp_o passed unchanged.
- A requester that drops valid in the middle of a group stalls the datapath indefinitely. This is by design: groups are atomic.

Test Plan:
1. Single requester, back-to-back samples.
   - Stimulus: req 2 sends samples 1,2,3.
   - Required: dp_i_dval pulses 3 times carrying 1,2,3; the datapath returns 6; rsp_dval=4'b0100, rsp_data=6; busy falls after the response.
2. Round-robin fairness.
   - Stimulus: all 4 requesters continuously valid; each sends k*10+{1,2,3}.
   - Required: groups are issued in order 0,1,2,3,0; responses are 6, 36, 66, 96, each with the matching one-hot rsp_dval.
3. Gaps within a locked group.
   - Stimulus: req 1 drives valid 1,0,0,1,0,1 with data 5,x,x,7,x,9; req 3 is valid throughout.
   - Required: req 3 gets no ready until req 1's 3rd accept; the response is 21 to requester 1.
4. Tag FIFO full.
   - Stimulus: hold datapath output off (model delay of 20 cycles); issue 5 groups.
   - Required: the 5th grant is stalled until the first dp_o_dval pop; there is no lost or duplicated rsp.
5. Orphan result.
   - Stimulus: inject dp_o_dval=1 with the FIFO empty.
   - Required: err_orphan=1 stays set; rsp_dval stays 0.
6. Reset mid-group.
   - Stimulus: assert rst=0 after 2 accepted samples; release; then req 0 sends 1,1,1.
   - Required: all outputs are 0 during reset; FIFO is empty; the next response is 3 to requester 0.

Source files
------------

// File: rtl/sm_arbiter.sv
// sm_arbiter: round-robin sharing of one sum-every-3 datapath between
// NREQ sample streams; a tag FIFO routes each returned sum to its owner.
module sm_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int OW   = 10,
    parameter int TAGQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               dp_i_dval,
    output logic [DW-1:0]      dp_i,
    input  logic               dp_o_dval,
    input  logic [OW-1:0]      dp_o,
    output logic [NREQ-1:0]    rsp_dval,
    output logic [OW-1:0]      rsp_data,
    output logic               busy,
    output logic               err_orphan
);
    localparam int TW = $clog2(NREQ);
    localparam int PW = (TAGQ > 1) ? $clog2(TAGQ) : 1;
    localparam int CW = $clog2(TAGQ + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] grant_q, grant_d;
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          dp_i_dval_q, dp_i_dval_d;
    logic [DW-1:0] dp_i_q, dp_i_d;
    logic [NREQ-1:0] rsp_dval_q, rsp_dval_d;
    logic [OW-1:0] rsp_data_q, rsp_data_d;
    logic          err_orphan_q, err_orphan_d;
    logic [TW-1:0] tag_mem [TAGQ];

    logic [TW-1:0] pick;
    logic [TW-1:0] cand;
    logic          found;
    logic          push, pop, accept, full, empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAGQ - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (occ_q == CW'(TAGQ));
    assign empty = (occ_q == '0);
    assign pop   = dp_o_dval && !empty;

    // Round-robin search: first valid requester after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = TW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Group FSM: grant a requester in IDLE, hold it for 3 accepts in LOCK.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        accept    = 1'b0;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid && !full) begin
                    grant_d = pick;
                    push    = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd2) begin
                        cnt_d    = 2'd0;
                        rr_ptr_d = grant_q;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath feed, tag FIFO bookkeeping and result routing.
    always_comb begin
        dp_i_dval_d  = accept;
        dp_i_d       = accept ? req_data[grant_q*DW +: DW] : dp_i_q;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d        = occ_q;
        if (push && !pop) occ_d = occ_q + CW'(1);
        if (pop && !push) occ_d = occ_q - CW'(1);
        rsp_dval_d   = '0;
        rsp_data_d   = rsp_data_q;
        if (pop) begin
            rsp_dval_d = {{(NREQ-1){1'b0}}, 1'b1} << tag_mem[rd_ptr_q];
            rsp_data_d = dp_o;
        end
        err_orphan_d = err_orphan_q | (dp_o_dval & empty);
    end

    // Tag storage; only the pointers need reset to make it empty.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_q] <= grant_d;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= TW'(NREQ - 1);
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            dp_i_dval_q  <= 1'b0;
            dp_i_q       <= '0;
            rsp_dval_q   <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            dp_i_dval_q  <= dp_i_dval_d;
            dp_i_q       <= dp_i_d;
            rsp_dval_q   <= rsp_dval_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign dp_i_dval  = dp_i_dval_q;
    assign dp_i       = dp_i_q;
    assign rsp_dval   = rsp_dval_q;
    assign rsp_data   = rsp_data_q;
    assign err_orphan = err_orphan_q;
    assign busy       = (state_q == LOCK) || !empty;

endmodule

// File: tb/tb_sm_arbiter.sv
// tb_sm_arbiter: scoreboard bench for sm_arbiter with a behavioural
// sum-every-3 datapath model and per-requester expected-sum queues.
module tb_sm_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int OW   = 10;
    localparam int TAGQ = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic               dp_i_dval;
    logic [DW-1:0]      dp_i;
    logic               dp_o_dval;
    logic [OW-1:0]      dp_o;
    logic [NREQ-1:0]    rsp_dval;
    logic [OW-1:0]      rsp_data;
    logic               busy;
    logic               err_orphan;

    logic               m_v = 1'b0;
    logic [OW-1:0]      m_d = '0;
    logic               inj_v = 1'b0;
    logic [OW-1:0]      inj_d = '0;

    assign dp_o_dval = m_v | inj_v;
    assign dp_o      = inj_v ? inj_d : m_d;

    sm_arbiter #(.NREQ(NREQ), .DW(DW), .OW(OW), .TAGQ(TAGQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .dp_i_dval(dp_i_dval), .dp_i(dp_i),
        .dp_o_dval(dp_o_dval), .dp_o(dp_o),
        .rsp_dval(rsp_dval), .rsp_data(rsp_data),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    int tx_q  [NREQ][$];
    bit gp_q  [NREQ][$];
    int exp_q [NREQ][$];
    int ord_q [$];
    int dpx_q [$];
    int pend_s[$];
    int pend_c[$];
    int acc_cnt [NREQ];
    int lat     = 3;
    int gap_pct = 0;
    int cyc     = 0;
    int grp     = 0;
    int rsp_n   = 0;
    int max_out = 0;
    bit ord_chk = 0;
    bit chk3    = 0;
    bit early3  = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        vec++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic push_group(input int k, input int a, input int b,
                              input int c);
        tx_q[k].push_back(a);
        tx_q[k].push_back(b);
        tx_q[k].push_back(c);
        exp_q[k].push_back(a + b + c);
    endtask

    function automatic bit all_empty();
        bit e;
        e = (pend_s.size() == 0) && !m_v;
        for (int k = 0; k < NREQ; k++)
            if (tx_q[k].size() != 0 || exp_q[k].size() != 0) e = 0;
        return e;
    endfunction

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (n < 3000 && !all_empty()) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drain"}, 32'(all_empty()), 1);
        repeat (2) @(negedge clk);
        check({nm, "_busy_low"}, 32'(busy), 0);
    endtask

    task automatic do_reset(input bit now);
        if (!now) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            tx_q[k].delete();
            gp_q[k].delete();
            exp_q[k].delete();
            acc_cnt[k] = 0;
        end
        ord_q.delete();
        dpx_q.delete();
        ord_chk = 0;
        chk3    = 0;
        early3  = 0;
        inj_v   = 1'b0;
        max_out = 0;
        #1;
        check("rst_dp_i_dval", 32'(dp_i_dval), 0);
        check("rst_dp_i", 32'(dp_i), 0);
        check("rst_rsp_dval", 32'(rsp_dval), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_err_orphan", 32'(err_orphan), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : dp_model
        int s, n;
        s = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                s = 0;
                n = 0;
                pend_s.delete();
                pend_c.delete();
            end else if (dp_i_dval) begin
                s += int'(dp_i);
                n++;
                if (n == 3) begin
                    pend_s.push_back(s);
                    pend_c.push_back(cyc + lat);
                    s = 0;
                    n = 0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst && pend_c.size() > 0 && pend_c[0] <= cyc) begin
                m_v = 1'b1;
                m_d = OW'(pend_s.pop_front());
                void'(pend_c.pop_front());
            end else begin
                m_v = 1'b0;
            end
        end
    end

    initial begin : drv
        bit [NREQ-1:0] accd;
        bit v;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            accd = rst ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (accd[k] && tx_q[k].size() > 0) begin
                    void'(tx_q[k].pop_front());
                    acc_cnt[k]++;
                end
                if (tx_q[k].size() > 0) begin
                    v = 1;
                    if (gp_q[k].size() > 0) v = gp_q[k].pop_front();
                    else if ($urandom_range(99) < gap_pct) v = 0;
                    req_valid[k] = v;
                    req_data[k*DW +: DW] = DW'(tx_q[k][0]);
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
        end
    end

    initial begin : mon
        bit pacc;
        logic [DW-1:0] pdat;
        logic [NREQ-1:0] prdy;
        int k, o;
        pacc = 0;
        pdat = '0;
        prdy = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pacc  = 0;
                prdy  = '0;
                grp   = 0;
                rsp_n = 0;
            end else begin
                if (rsp_dval != '0) begin
                    check("rsp_onehot", 32'($onehot(rsp_dval)), 1);
                    k = 0;
                    for (int j = NREQ - 1; j >= 0; j--)
                        if (rsp_dval[j]) k = j;
                    if (exp_q[k].size() == 0)
                        check("rsp_extra_pending", 0, 1);
                    else
                        check("rsp_data", 32'(rsp_data), exp_q[k].pop_front());
                    if (ord_chk) begin
                        if (ord_q.size() == 0) check("rsp_order_pending", 0, 1);
                        else check("rsp_order", k, ord_q.pop_front());
                    end
                    rsp_n++;
                end
                check("dp_i_dval_lat", 32'(dp_i_dval), 32'(pacc));
                if (pacc) check("dp_i_data", 32'(dp_i), 32'(pdat));
                if (dp_i_dval && dpx_q.size() > 0)
                    check("dp_i_seq", 32'(dp_i), dpx_q.pop_front());
                pacc = 0;
                for (int j = 0; j < NREQ; j++)
                    if (req_valid[j] && req_ready[j]) begin
                        pacc = 1;
                        pdat = req_data[j*DW +: DW];
                    end
                if (req_ready != '0 && prdy == '0) begin
                    grp++;
                    o = grp - rsp_n;
                    if (o > max_out) max_out = o;
                    check("outstanding_bound", 32'(o <= TAGQ), 1);
                end
                if (chk3 && req_ready[3] && acc_cnt[1] < 3) early3 = 1;
                prdy = req_ready;
            end
        end
    end

    initial begin : main
        int n, ng;
        do_reset(0);

        lat = 3;
        ord_chk = 1;
        push_group(2, 1, 2, 3);
        ord_q.push_back(2);
        for (int i = 1; i <= 3; i++) dpx_q.push_back(i);
        drain("t1");
        check("t1_dp_seq_done", dpx_q.size(), 0);

        do_reset(0);
        ord_chk = 1;
        push_group(0, 1, 2, 3);
        for (int k = 1; k < NREQ; k++)
            push_group(k, k*10 + 1, k*10 + 2, k*10 + 3);
        push_group(0, 1, 2, 3);
        for (int k = 0; k <= NREQ; k++) begin
            ord_q.push_back(k % NREQ);
            for (int i = 1; i <= 3; i++) dpx_q.push_back((k % NREQ)*10 + i);
        end
        drain("t2");
        check("t2_dp_seq_done", dpx_q.size(), 0);

        do_reset(0);
        ord_chk = 1;
        chk3 = 1;
        push_group(1, 5, 6, 7);
        tx_q[1].delete();
        exp_q[1].delete();
        push_group(1, 5, 7, 9);
        push_group(3, 30, 31, 32);
        gp_q[1] = '{1, 1, 0, 0, 1, 0, 1};
        ord_q.push_back(1);
        ord_q.push_back(3);
        drain("t3");
        check("t3_no_early_ready3", 32'(early3), 0);

        do_reset(0);
        lat = 20;
        for (int g = 0; g < 5; g++) push_group(2, g + 1, g + 2, g + 3);
        drain("t4");
        check("t4_fifo_filled", max_out, TAGQ);

        do_reset(0);
        lat = 3;
        @(posedge clk);
        #1;
        inj_v = 1'b1;
        inj_d = OW'(123);
        @(posedge clk);
        #1;
        inj_v = 1'b0;
        @(negedge clk);
        check("t5_orphan_set", 32'(err_orphan), 1);
        check("t5_no_rsp", 32'(rsp_dval), 0);
        repeat (5) @(negedge clk);
        check("t5_orphan_sticky", 32'(err_orphan), 1);
        push_group(1, 4, 5, 6);
        drain("t5");
        check("t5_orphan_kept", 32'(err_orphan), 1);

        do_reset(0);
        push_group(0, 50, 60, 70);
        n = 0;
        while (n < 100 && acc_cnt[0] < 2) begin
            @(negedge clk);
            n++;
        end
        check("t6_two_accepts", acc_cnt[0], 2);
        #1;
        do_reset(1);
        ord_chk = 1;
        push_group(0, 1, 1, 1);
        ord_q.push_back(0);
        drain("t6");

        for (int r = 0; r < 4; r++) begin
            do_reset(0);
            lat = $urandom_range(1, 24);
            gap_pct = 25;
            for (int k = 0; k < NREQ; k++) begin
                ng = $urandom_range(0, 3);
                for (int g = 0; g < ng; g++)
                    push_group(k, $urandom_range(255), $urandom_range(255),
                               $urandom_range(255));
            end
            drain("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
